// File: rtl/uart_pkg.sv
// Shared UART definitions used by the auto-baud controller.
//   ab_state_t   : auto-baud FSM states
//   AB_*         : calibration-frame timing constants
//   BAUD_*       : legal range / width of the 16x baud divider
package uart_pkg;

    typedef enum logic [2:0] {
        AB_IDLE,
        AB_WAIT_QUIET,
        AB_WAIT_FALL,
        AB_MEASURE,
        AB_CALC,
        AB_LOCKED,
        AB_ERR
    } ab_state_t;

    localparam int AB_TOL_SHIFT = 2;    // segment tolerance = T1 >> 2 (+/-25%)
    localparam int AB_EDGES     = 8;    // edges after t0 in a 0x55 frame
    localparam int AB_ROUND     = 64;   // half of 128 = 8 bits * 16x oversample
    localparam int AB_SHIFT     = 7;
    localparam int BAUD_MIN     = 2;
    localparam int BAUD_MAX     = 4095;
    localparam int BAUD_W       = 12;

endpackage

// File: rtl/double_sync_high.sv
// Two-flop synchronizer for an asynchronous input whose idle level is 1.
//   clk : destination clock
//   rst : asynchronous active-high reset, flops reset to 1
//   d   : asynchronous input
//   q   : synchronized output (2 cycles latency)
module double_sync_high (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_auto_baud.sv
// Auto-baud controller: times a 0x55 calibration frame on rxd and derives the
// UART core's 16x baud divider from it.
//   app_clk, arst    : clock, asynchronous active-high reset
//   cfg_auto_en      : 1 selects the measured divider (when locked)
//   cfg_sw_baud      : software divider
//   ab_start         : pulse, arm / re-arm a measurement
//   rxd              : raw asynchronous UART line
//   cfg_baud_16x     : divider to the UART core
//   ab_busy          : measurement in progress
//   ab_locked        : a valid measured divider is held
//   ab_done, ab_err  : one-cycle success / failure pulses
module uart_auto_baud
    import uart_pkg::*;
#(
    parameter int CNT_W    = 20,
    parameter int IDLE_MIN = 64
) (
    input  logic              app_clk,
    input  logic              arst,
    input  logic              cfg_auto_en,
    input  logic [BAUD_W-1:0] cfg_sw_baud,
    input  logic              ab_start,
    input  logic              rxd,
    output logic [BAUD_W-1:0] cfg_baud_16x,
    output logic              ab_busy,
    output logic              ab_locked,
    output logic              ab_done,
    output logic              ab_err
);

    logic              rxd_s;
    logic              rxd_prev_q, rxd_prev_d;
    ab_state_t         state_q, state_d;
    logic [CNT_W-1:0]  seg_cnt_q, seg_cnt_d;
    logic [CNT_W-1:0]  tot_cnt_q, tot_cnt_d;
    logic [CNT_W-1:0]  t1_q, t1_d;
    logic [3:0]        edge_idx_q, edge_idx_d;
    logic [BAUD_W-1:0] meas_baud_q, meas_baud_d;
    logic              locked_q, locked_d;
    logic              done_q, done_d;

    logic              rx_edge, rx_fall, seg_ok;
    logic [CNT_W-1:0]  seg_len, tol;
    logic [CNT_W:0]    hi_lim, rnd_sum;
    logic signed [CNT_W:0] div_s;

    double_sync_high u_sync (
        .clk (app_clk),
        .rst (arst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign rxd_prev_d = rxd_s;
    assign rx_edge    = rxd_s ^ rxd_prev_q;
    assign rx_fall    = rxd_prev_q & ~rxd_s;

    // The counter is cleared on the edge cycle itself, so the finished
    // segment is one longer than the count held on the next edge cycle.
    assign seg_len = seg_cnt_q + CNT_W'(1);
    assign tol     = t1_q >> AB_TOL_SHIFT;
    assign hi_lim  = {1'b0, t1_q} + {1'b0, tol};
    assign seg_ok  = (seg_len >= (t1_q - tol)) && ({1'b0, seg_len} <= hi_lim);

    // 8 bit times = 128 16x ticks; round to nearest, minus 2 for the core's
    // reload overhead. Signed so tiny frames show up as negative.
    assign rnd_sum = {1'b0, tot_cnt_q} + (CNT_W+1)'(AB_ROUND);
    assign div_s   = $signed((rnd_sum >> AB_SHIFT) - (CNT_W+1)'(BAUD_MIN));

    always_comb begin
        state_d     = state_q;
        seg_cnt_d   = seg_cnt_q;
        tot_cnt_d   = tot_cnt_q;
        t1_d        = t1_q;
        edge_idx_d  = edge_idx_q;
        meas_baud_d = meas_baud_q;
        locked_d    = locked_q;
        done_d      = 1'b0;

        case (state_q)
            AB_IDLE, AB_LOCKED: begin
                if (ab_start) begin
                    state_d   = AB_WAIT_QUIET;
                    seg_cnt_d = '0;
                end
            end
            AB_WAIT_QUIET: begin
                if (!rxd_s)
                    seg_cnt_d = '0;
                else if (seg_cnt_q == CNT_W'(IDLE_MIN - 1))
                    state_d = AB_WAIT_FALL;
                else
                    seg_cnt_d = seg_cnt_q + CNT_W'(1);
            end
            AB_WAIT_FALL: begin
                if (rx_fall) begin
                    state_d    = AB_MEASURE;
                    seg_cnt_d  = '0;
                    tot_cnt_d  = '0;
                    edge_idx_d = '0;
                end
            end
            AB_MEASURE: begin
                seg_cnt_d = seg_cnt_q + CNT_W'(1);
                // tot saturates; an overflowed total then fails the range check
                if (tot_cnt_q != '1) tot_cnt_d = tot_cnt_q + CNT_W'(1);
                if (seg_cnt_q == '1) begin
                    state_d = AB_ERR;
                end else if (rx_edge) begin
                    seg_cnt_d  = '0;
                    edge_idx_d = edge_idx_q + 4'd1;
                    if (edge_idx_q == 4'd0)
                        t1_d = seg_len;
                    else if (!seg_ok)
                        state_d = AB_ERR;
                    else if (edge_idx_q == 4'(AB_EDGES - 1))
                        state_d = AB_CALC;   // tot_cnt_d now holds t0->t8
                end
            end
            AB_CALC: begin
                if (int'(div_s) < BAUD_MIN || int'(div_s) > BAUD_MAX) begin
                    state_d = AB_ERR;
                end else begin
                    state_d     = AB_LOCKED;
                    meas_baud_d = BAUD_W'(div_s);
                    locked_d    = 1'b1;
                    done_d      = 1'b1;
                end
            end
            AB_ERR:  state_d = AB_IDLE;
            default: state_d = AB_IDLE;
        endcase

        // Re-arm while busy: silent restart, nothing committed from this pass.
        if (ab_start && ab_busy) begin
            state_d     = AB_WAIT_QUIET;
            seg_cnt_d   = '0;
            tot_cnt_d   = '0;
            edge_idx_d  = '0;
            meas_baud_d = meas_baud_q;
            locked_d    = locked_q;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge app_clk or posedge arst) begin
        if (arst) begin
            rxd_prev_q  <= 1'b1;
            state_q     <= AB_IDLE;
            seg_cnt_q   <= '0;
            tot_cnt_q   <= '0;
            t1_q        <= '0;
            edge_idx_q  <= '0;
            meas_baud_q <= '0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rxd_prev_q  <= rxd_prev_d;
            state_q     <= state_d;
            seg_cnt_q   <= seg_cnt_d;
            tot_cnt_q   <= tot_cnt_d;
            t1_q        <= t1_d;
            edge_idx_q  <= edge_idx_d;
            meas_baud_q <= meas_baud_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
        end
    end

    assign ab_busy      = (state_q == AB_WAIT_QUIET) || (state_q == AB_WAIT_FALL) ||
                          (state_q == AB_MEASURE)    || (state_q == AB_CALC);
    assign ab_err       = (state_q == AB_ERR);
    assign ab_done      = done_q;
    assign ab_locked    = locked_q;
    assign cfg_baud_16x = (cfg_auto_en && locked_q) ? meas_baud_q : cfg_sw_baud;

endmodule

// File: tb/tb_uart_auto_baud.sv
module tb_uart_auto_baud;

    logic        app_clk = 1'b0;
    logic        arst = 1'b1;
    logic        cfg_auto_en = 1'b1;
    logic [11:0] cfg_sw_baud = 12'h0A0;
    logic        ab_start = 1'b0;
    logic        rxd = 1'b1;
    logic [11:0] cfg_baud_16x;
    logic        ab_busy, ab_locked, ab_done, ab_err;

    // Second instance with a short counter so the timeout is reachable quickly.
    logic        ab_start_t = 1'b0;
    logic        rxd_t = 1'b1;
    logic [11:0] cfg_baud_16x_t;
    logic        ab_busy_t, ab_locked_t, ab_done_t, ab_err_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          err_cnt_t = 0;
    logic [11:0] done_baud = '0;
    logic        done_locked = 1'b0;

    uart_auto_baud #(.CNT_W(20), .IDLE_MIN(64)) dut (
        .app_clk      (app_clk),
        .arst         (arst),
        .cfg_auto_en  (cfg_auto_en),
        .cfg_sw_baud  (cfg_sw_baud),
        .ab_start     (ab_start),
        .rxd          (rxd),
        .cfg_baud_16x (cfg_baud_16x),
        .ab_busy      (ab_busy),
        .ab_locked    (ab_locked),
        .ab_done      (ab_done),
        .ab_err       (ab_err)
    );

    uart_auto_baud #(.CNT_W(10), .IDLE_MIN(64)) dut_t (
        .app_clk      (app_clk),
        .arst         (arst),
        .cfg_auto_en  (cfg_auto_en),
        .cfg_sw_baud  (cfg_sw_baud),
        .ab_start     (ab_start_t),
        .rxd          (rxd_t),
        .cfg_baud_16x (cfg_baud_16x_t),
        .ab_busy      (ab_busy_t),
        .ab_locked    (ab_locked_t),
        .ab_done      (ab_done_t),
        .ab_err       (ab_err_t)
    );

    always #5 app_clk = ~app_clk;

    // Pulse monitor: counts high cycles and snapshots outputs on ab_done.
    always @(negedge app_clk) begin
        if (ab_done) begin
            done_cnt    <= done_cnt + 1;
            done_baud   <= cfg_baud_16x;
            done_locked <= ab_locked;
        end
        if (ab_err)   err_cnt   <= err_cnt + 1;
        if (ab_err_t) err_cnt_t <= err_cnt_t + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge app_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int bt);
        rxd = 1'b0;
        cyc(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cyc(bt);
        end
        rxd = 1'b1;
        cyc(bt);
    endtask

    task automatic arm();
        ab_start = 1'b1;
        cyc(1);
        ab_start = 1'b0;
        cyc(80);
    endtask

    initial begin
        int w;
        cyc(3);
        chk("rst_busy",   32'(ab_busy), 32'd0);
        chk("rst_locked", 32'(ab_locked), 32'd0);
        chk("rst_done",   32'(ab_done), 32'd0);
        chk("rst_err",    32'(ab_err), 32'd0);
        chk("rst_cfg",    32'(cfg_baud_16x), 32'h0A0);
        arst = 1'b0;
        cyc(2);

        // 434-cycle bits: tot 3472 -> 25
        ab_start = 1'b1;
        cyc(1);
        ab_start = 1'b0;
        chk("arm_busy", 32'(ab_busy), 32'd1);
        cyc(79);
        send(8'h55, 434);
        cyc(5);
        chk("t434_done_cnt", 32'(done_cnt), 32'd1);
        chk("t434_done_cfg", 32'(done_baud), 32'd25);
        chk("t434_done_lck", 32'(done_locked), 32'd1);
        chk("t434_cfg",      32'(cfg_baud_16x), 32'd25);
        chk("t434_locked",   32'(ab_locked), 32'd1);
        chk("t434_busy",     32'(ab_busy), 32'd0);
        chk("t434_err_cnt",  32'(err_cnt), 32'd0);

        // output mux follows cfg_auto_en combinationally
        cfg_auto_en = 1'b0;
        #1;
        chk("mux_sw", 32'(cfg_baud_16x), 32'h0A0);
        cfg_auto_en = 1'b1;
        #1;
        chk("mux_auto", 32'(cfg_baud_16x), 32'd25);

        // 5208-cycle bits: tot 41664 -> 324
        arm();
        send(8'h55, 5208);
        cyc(5);
        chk("t5208_cfg",      32'(cfg_baud_16x), 32'd324);
        chk("t5208_done_cnt", 32'(done_cnt), 32'd2);

        // 0x0D: a double-length segment fails, old lock kept
        arm();
        send(8'h0D, 434);
        cyc(5);
        chk("x0d_err_cnt",  32'(err_cnt), 32'd1);
        chk("x0d_cfg",      32'(cfg_baud_16x), 32'd324);
        chk("x0d_locked",   32'(ab_locked), 32'd1);
        chk("x0d_done_cnt", 32'(done_cnt), 32'd2);

        // re-arm after 4 edges, then a clean frame
        arm();
        rxd = 1'b0; cyc(434);
        rxd = 1'b1; cyc(434);
        rxd = 1'b0; cyc(434);
        rxd = 1'b1; cyc(200);
        ab_start = 1'b1;
        cyc(1);
        ab_start = 1'b0;
        cyc(100);
        send(8'h55, 434);
        cyc(5);
        chk("rearm_err_cnt",  32'(err_cnt), 32'd1);
        chk("rearm_done_cnt", 32'(done_cnt), 32'd3);
        chk("rearm_done_cfg", 32'(done_baud), 32'd25);
        chk("rearm_cfg",      32'(cfg_baud_16x), 32'd25);

        // asynchronous reset in the middle of MEASURE
        arm();
        rxd = 1'b0;
        cyc(100);
        chk("mid_busy", 32'(ab_busy), 32'd1);
        #2 arst = 1'b1;
        #1;
        chk("arst_busy",   32'(ab_busy), 32'd0);
        chk("arst_locked", 32'(ab_locked), 32'd0);
        chk("arst_done",   32'(ab_done), 32'd0);
        chk("arst_err",    32'(ab_err), 32'd0);
        chk("arst_cfg",    32'(cfg_baud_16x), 32'h0A0);
        rxd = 1'b1;
        cyc(2);
        arst = 1'b0;
        cyc(2);

        // 8-cycle bits: tot 64 -> div -1 -> error, stays unlocked
        arm();
        send(8'h55, 8);
        cyc(5);
        chk("tiny_err_cnt",  32'(err_cnt), 32'd2);
        chk("tiny_locked",   32'(ab_locked), 32'd0);
        chk("tiny_cfg",      32'(cfg_baud_16x), 32'h0A0);
        chk("tiny_done_cnt", 32'(done_cnt), 32'd3);

        // timeout: line stuck low after the start fall (CNT_W = 10)
        ab_start_t = 1'b1;
        cyc(1);
        ab_start_t = 1'b0;
        cyc(80);
        rxd_t = 1'b0;
        cyc(900);
        chk("to_busy_early", 32'(ab_busy_t), 32'd1);
        chk("to_no_err_yet", 32'(err_cnt_t), 32'd0);
        w = 0;
        while (!ab_err_t && w < 400) begin
            cyc(1);
            w++;
        end
        chk("to_err_seen", 32'(ab_err_t), 32'd1);
        cyc(2);
        chk("to_busy_after", 32'(ab_busy_t), 32'd0);
        chk("to_err_cnt",    32'(err_cnt_t), 32'd1);
        chk("to_locked",     32'(ab_locked_t), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
